// File: rtl/proc_scan_pkg.sv
// Shared types and constants for the process-scan block: FSM states,
// CPU control/status bit positions and the timer clear-ready command code.
package proc_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_PICK,
    ST_CLR,
    ST_DONE
  } state_t;

  localparam int CTRL_SCAN     = 0;
  localparam int CTRL_SET_MASK = 1;
  localparam int CTRL_CLR_MASK = 2;
  localparam int CTRL_RST_PTR  = 3;

  localparam int STAT_BUSY  = 31;
  localparam int STAT_FOUND = 30;
  localparam int STAT_DONE  = 29;
  localparam int STAT_ERR   = 28;

  localparam logic [7:0] PT_CLR_READY = 8'h08;

  function automatic logic [31:0] clr_ready_word(input logic [4:0] pid);
    return {16'h0, 3'b000, pid, PT_CLR_READY};
  endfunction

endpackage

// File: rtl/proc_scan_if.sv
// CPU-side slave bus and process-timer initiator bus of proc_scan.
// slave is the proc_scan view; master is the CPU plus timer view.
interface proc_scan_if;
  logic        stb;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        pt_stb;
  logic        pt_we;
  logic [31:0] pt_data_out;
  logic [31:0] pt_data_in;
  logic        pt_ack;

  modport slave (
    input  stb, we, data_in, pt_data_in, pt_ack,
    output data_out, ack, pt_stb, pt_we, pt_data_out
  );

  modport master (
    output stb, we, data_in, pt_data_in, pt_ack,
    input  data_out, ack, pt_stb, pt_we, pt_data_out
  );
endinterface

// File: rtl/proc_scan_rr_pick.sv
// Combinational 32-way rotating-priority picker: first set bit of vec
// at or after start, wrapping from bit 31 back to bit 0.
module rr_pick (
  input  logic [31:0] vec,
  input  logic [4:0]  start,
  output logic        hit,
  output logic [4:0]  idx
);

  logic [4:0] pos;

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int i = 0; i < 32; i++) begin
      pos = start + 5'(i);
      if (!hit && vec[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/proc_scan.sv
// Scans the process-timer ready vector, picks the next ready process
// round-robin past the last one served, and issues a clear-ready for it.
module proc_scan
  import proc_scan_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input logic         clk,
  input logic         rst_n,
  proc_scan_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [31:0]     mask;
  logic [31:0]     vec;
  logic [4:0]      last;
  logic [4:0]      pid;
  logic            found, done, err;
  logic [CW-1:0]   wait_cnt;
  logic            timeout;
  logic            hit;
  logic [4:0]      pick_idx;

  logic [7:0]      ctrl;
  logic [4:0]      wpid;
  logic            wr, req;
  logic            unused_bits;

  assign ctrl        = bus.data_in[7:0];
  assign wpid        = bus.data_in[12:8];
  assign wr          = bus.stb && bus.we;
  assign req         = wr && ctrl[CTRL_SCAN] && (state == ST_IDLE);
  assign unused_bits = ^{bus.data_in[31:13], ctrl[7:4]};

  assign bus.ack      = bus.stb;
  assign bus.data_out = (bus.stb && !bus.we)
                      ? {state != ST_IDLE, found, done, err, 23'h0, pid}
                      : 32'h0;

  rr_pick u_pick (
    .vec   (vec),
    .start (last + 5'd1),
    .hit   (hit),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt       = state;
    bus.pt_stb      = 1'b0;
    bus.pt_we       = 1'b0;
    bus.pt_data_out = 32'h0;
    timeout         = 1'b0;
    case (state)
      ST_IDLE: if (req) state_nxt = ST_RD;
      ST_RD: begin
        bus.pt_stb = 1'b1;
        timeout    = !bus.pt_ack && (wait_cnt == CW'(TIMEOUT - 1));
        if (bus.pt_ack)   state_nxt = ST_PICK;
        else if (timeout) state_nxt = ST_DONE;
      end
      ST_PICK: state_nxt = hit ? ST_CLR : ST_DONE;
      ST_CLR: begin
        bus.pt_stb      = 1'b1;
        bus.pt_we       = 1'b1;
        bus.pt_data_out = clr_ready_word(pid);
        timeout         = !bus.pt_ack && (wait_cnt == CW'(TIMEOUT - 1));
        if (bus.pt_ack || timeout) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mask     <= 32'hFFFF_FFFF;
      vec      <= 32'h0;
      last     <= 5'd31;
      pid      <= 5'd0;
      found    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state_nxt != state) ? '0 : wait_cnt + CW'(bus.pt_stb);
      case (state)
        // pid is stale once a new scan starts, so it is cleared with the flags
        ST_IDLE: if (req) begin
          found <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
          pid   <= 5'd0;
        end
        ST_RD: if (bus.pt_ack) begin
          vec <= bus.pt_data_in & mask;
        end else if (timeout) begin
          err  <= 1'b1;
          found <= 1'b0;
          done <= 1'b1;
        end
        ST_PICK: if (hit) begin
          pid <= pick_idx;
        end else begin
          found <= 1'b0;
          done  <= 1'b1;
        end
        ST_CLR: if (bus.pt_ack) begin
          found <= 1'b1;
          done  <= 1'b1;
          last  <= pid;
        end else if (timeout) begin
          err   <= 1'b1;
          found <= 1'b0;
          done  <= 1'b1;
        end
        default: ;
      endcase
      // CPU mask/pointer writes act at once, even mid-scan, and win over the FSM
      if (wr) begin
        if (ctrl[CTRL_CLR_MASK])      mask[wpid] <= 1'b0;
        else if (ctrl[CTRL_SET_MASK]) mask[wpid] <= 1'b1;
        if (ctrl[CTRL_RST_PTR])       last <= 5'd31;
      end
    end
  end

endmodule

// File: tb/tb_proc_scan.sv
// Self-checking bench for proc_scan: a behavioural process-timer responder,
// a reference pick model, and scoreboard queues of expected results.
module tb_proc_scan;

  logic clk;
  logic rst_n;
  proc_scan_if bus ();

  logic [31:0] ready;
  logic        ack_rd, ack_clr;
  int          n_vec, n_err;
  int          rd_cnt, stb_cyc;
  logic [31:0] clr_q[$];
  logic [31:0] exp_st_q[$];
  logic [4:0]  exp_pid_q[$];
  logic [31:0] m_mask;
  int          m_last;

  proc_scan #(.TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.pt_data_in = ready;
  assign bus.pt_ack     = bus.pt_stb && (bus.pt_we ? ack_clr : ack_rd);

  // Process-timer model: counts handshakes and applies clear-ready commands.
  always @(posedge clk) begin
    if (rst_n && bus.pt_stb) stb_cyc++;
    if (rst_n && bus.pt_stb && bus.pt_ack) begin
      if (bus.pt_we) begin
        clr_q.push_back(bus.pt_data_out);
        if (bus.pt_data_out[7:0] == 8'h08) ready[bus.pt_data_out[12:8]] = 1'b0;
      end else begin
        rd_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int model_pick(input logic [31:0] v, input int from);
    for (int k = 1; k <= 32; k++) begin
      int p;
      p = (from + k) % 32;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [31:0] clr_cmd(input int p);
    logic [31:0] w;
    w = 32'h0000_0008;
    w[12:8] = p[4:0];
    return w;
  endfunction

  task automatic cpu_write(input logic [31:0] d);
    @(negedge clk);
    bus.stb = 1'b1; bus.we = 1'b1; bus.data_in = d;
    @(negedge clk);
    bus.stb = 1'b0; bus.we = 1'b0; bus.data_in = 32'h0;
  endtask

  task automatic cpu_read(output logic [31:0] d);
    @(negedge clk);
    bus.stb = 1'b1; bus.we = 1'b0;
    #1 d = bus.data_out;
    bus.stb = 1'b0;
  endtask

  task automatic mask_write(input logic [7:0] ctrl, input int p);
    logic [31:0] d;
    d = {19'h0, p[4:0], ctrl};
    cpu_write(d);
    if (ctrl[2])      m_mask[p] = 1'b0;
    else if (ctrl[1]) m_mask[p] = 1'b1;
    if (ctrl[3])      m_last = 31;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    bit ok;
    ok = 1'b0;
    s  = 32'h0;
    for (int i = 0; i < 100 && !ok; i++) begin
      cpu_read(s);
      if (!s[31]) ok = 1'b1;
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_idle: status %h still busy, required busy=0", tag, s);
    end
  endtask

  task automatic run_scan(input logic [31:0] rv, input string tag);
    int p;
    logic [31:0] s, exp_s, obs;
    ready = rv;
    p = model_pick(rv & m_mask, m_last);
    if (p >= 0) begin
      exp_st_q.push_back(32'h6000_0000 | 32'(p));
      exp_pid_q.push_back(p[4:0]);
      m_last = p;
    end else begin
      exp_st_q.push_back(32'h2000_0000);
    end
    cpu_write(32'h1);
    wait_idle(tag);
    cpu_read(s);
    exp_s = exp_st_q.pop_front();
    n_vec++;
    if (s !== exp_s) begin
      n_err++;
      $display("FAIL %s_status: got %h required %h", tag, s, exp_s);
    end
    n_vec++;
    if (p >= 0) begin
      if (clr_q.size() != 1) begin
        n_err++;
        $display("FAIL %s_clr_count: got %0d required 1", tag, clr_q.size());
      end else begin
        obs = clr_q.pop_front();
        exp_s = clr_cmd(int'(exp_pid_q.pop_front()));
        if (obs !== exp_s) begin
          n_err++;
          $display("FAIL %s_clr_word: got %h required %h", tag, obs, exp_s);
        end
      end
    end else if (clr_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_no_clr: got %0d clears required 0", tag, clr_q.size());
    end
    clr_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] s;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if ({bus.pt_stb, bus.pt_we} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_pt_ctl: got %b required 00", {bus.pt_stb, bus.pt_we});
    end
    n_vec++;
    if (bus.pt_data_out !== 32'h0) begin
      n_err++;
      $display("FAIL reset_pt_data: got %h required 0", bus.pt_data_out);
    end
    n_vec++;
    if (bus.data_out !== 32'h0 || bus.ack !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_bus: data_out %h ack %b required 0 0", bus.data_out, bus.ack);
    end
    cpu_read(s);
    n_vec++;
    if (s !== 32'h0) begin
      n_err++;
      $display("FAIL reset_status: got %h required 0", s);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    logic [31:0] s;
    int rd0;
    rd0 = rd_cnt;
    ready = 32'h0000_0014;
    cpu_write(32'h1);
    #1;
    n_vec++;
    if ({bus.pt_stb, bus.pt_we, bus.pt_data_out} !== {2'b10, 32'h0}) begin
      n_err++;
      $display("FAIL lat_rd: stb/we %b data %h required 10 0", {bus.pt_stb, bus.pt_we}, bus.pt_data_out);
    end
    @(negedge clk); #1;
    n_vec++;
    if (bus.pt_stb !== 1'b0) begin
      n_err++;
      $display("FAIL lat_pick: pt_stb %b required 0", bus.pt_stb);
    end
    @(negedge clk); #1;
    n_vec++;
    if ({bus.pt_stb, bus.pt_we, bus.pt_data_out} !== {2'b11, 32'h0000_0208}) begin
      n_err++;
      $display("FAIL lat_clr: stb/we %b data %h required 11 00000208", {bus.pt_stb, bus.pt_we}, bus.pt_data_out);
    end
    cpu_read(s);
    n_vec++;
    if (s !== 32'hE000_0002) begin
      n_err++;
      $display("FAIL lat_done: got %h required e0000002", s);
    end
    cpu_read(s);
    n_vec++;
    if (s !== 32'h6000_0002) begin
      n_err++;
      $display("FAIL lat_idle: got %h required 60000002", s);
    end
    n_vec++;
    if (clr_q.size() != 1 || rd_cnt - rd0 != 1) begin
      n_err++;
      $display("FAIL lat_txns: clears %0d reads %0d required 1 1", clr_q.size(), rd_cnt - rd0);
    end else if (clr_q[0] !== 32'h0000_0208) begin
      n_err++;
      $display("FAIL lat_clr_word: got %h required 00000208", clr_q[0]);
    end
    clr_q.delete();
    m_last = 2;
    run_scan(ready, "second");
  endtask

  task automatic test_wrap();
    mask_write(8'h08, 0);
    run_scan(32'h8000_0001, "wrap_a");
    run_scan(32'h8000_0001, "wrap_b");
    run_scan(32'h8000_0001, "wrap_c");
  endtask

  task automatic test_mask();
    mask_write(8'h04, 2);
    run_scan(32'h0000_0004, "masked");
    mask_write(8'h02, 2);
    mask_write(8'h06, 1);
    run_scan(32'h0000_0002, "clr_wins");
    mask_write(8'h02, 1);
    run_scan(32'h0000_0006, "unmasked");
  endtask

  task automatic test_timeout();
    logic [31:0] s;
    int c0, rd0;
    c0 = stb_cyc;
    rd0 = rd_cnt;
    ack_rd = 1'b0;
    ready = 32'h0000_0001;
    cpu_write(32'h1);
    wait_idle("timeout");
    ack_rd = 1'b1;
    n_vec++;
    if (stb_cyc - c0 != 15 || rd_cnt != rd0) begin
      n_err++;
      $display("FAIL timeout_cycles: stb cycles %0d reads %0d required 15 0", stb_cyc - c0, rd_cnt - rd0);
    end
    cpu_read(s);
    n_vec++;
    if (s !== 32'h3000_0000) begin
      n_err++;
      $display("FAIL timeout_status: got %h required 30000000", s);
    end
    clr_q.delete();
  endtask

  task automatic test_back_to_back();
    int rd0;
    rd0 = rd_cnt;
    run_scan(32'h0000_0108, "busy_first");
    rd0 = rd_cnt;
    ready = 32'h0000_0008;
    m_last = model_pick(ready & m_mask, m_last);
    cpu_write(32'h1);
    cpu_write(32'h1);
    wait_idle("busy");
    repeat (5) @(negedge clk);
    n_vec++;
    if (rd_cnt - rd0 != 1 || clr_q.size() != 1) begin
      n_err++;
      $display("FAIL busy_ignored: reads %0d clears %0d required 1 1", rd_cnt - rd0, clr_q.size());
    end else if (clr_q[0] !== clr_cmd(m_last)) begin
      n_err++;
      $display("FAIL busy_clr_word: got %h required %h", clr_q[0], clr_cmd(m_last));
    end
    clr_q.delete();
  endtask

  task automatic test_reset_mid_clr();
    logic [31:0] s;
    bit seen;
    mask_write(8'h04, 0);
    ack_clr = 1'b0;
    ready = 32'h0000_0011;
    cpu_write(32'h1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      #1 if (bus.pt_we) seen = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL rst_reach_clr: pt_we %b required 1", bus.pt_we);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_vec++;
    if (bus.pt_stb !== 1'b0) begin
      n_err++;
      $display("FAIL rst_pt_stb: got %b required 0", bus.pt_stb);
    end
    cpu_read(s);
    n_vec++;
    if (s !== 32'h0 || clr_q.size() != 0) begin
      n_err++;
      $display("FAIL rst_status: got %h clears %0d required 0 0", s, clr_q.size());
    end
    rst_n = 1'b1;
    ack_clr = 1'b1;
    m_mask = 32'hFFFF_FFFF;
    m_last = 31;
    run_scan(32'h0000_0011, "post_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stb = 1'b0; bus.we = 1'b0; bus.data_in = 32'h0;
    ready = 32'h0; ack_rd = 1'b1; ack_clr = 1'b1;
    n_vec = 0; n_err = 0; rd_cnt = 0; stb_cyc = 0;
    m_mask = 32'hFFFF_FFFF;
    m_last = 31;
    test_reset();
    test_latency();
    test_wrap();
    test_mask();
    test_timeout();
    test_back_to_back();
    test_reset_mid_clr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/proc_scan.md
PROC_SCAN -- requirements
Module: proc_scan

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles to wait for pt_ack before abort.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 stb  input  1  CPU-side access strobe.
REQ-005 we  input  1  CPU-side write enable (1 write, 0 read).
REQ-006 data_in  input  32  CPU write data: [7:0] ctrl, [12:8] pid.
REQ-007 data_out  output  32  CPU read data: status word; 0 when not reading.
REQ-008 ack  output  1  CPU-side acknowledge, equals stb.
REQ-009 pt_stb  output  1  initiator strobe to the process-timer block.
REQ-010 pt_we  output  1  initiator write enable.
REQ-011 pt_data_out  output  32  initiator write data.
REQ-012 pt_data_in  input  32  process-timer ready vector, bit n = process n ready.
REQ-013 pt_ack  input  1  process-timer acknowledge.

Function
REQ-014 CPU write ctrl bits: [0] request scan, [1] set mask[pid], [2] clear mask[pid], [3] reset round-robin pointer last to 31.
- Multiple ctrl bits in one write: mask and pointer ops apply; ctrl[2] wins over ctrl[1].
REQ-015 ctrl[0] while busy is ignored; mask/pointer writes while busy take effect immediately, but the vector already captured is not re-masked.
REQ-016 FSM states IDLE, RD, PICK, CLR, DONE.
- IDLE -> RD on ctrl[0].
- RD: pt_stb=1, pt_we=0, pt_data_out=0; on pt_ack capture pt_data_in & mask -> PICK.
- PICK, one cycle: rotating priority search starting at (last+1) mod 32, wrapping; hit -> CLR with pid latched; no hit -> DONE, found=0.
- CLR: pt_stb=1, pt_we=1, pt_data_out={16'h0, 3'b0, pid, 8'h08}, i.e. clear-ready for pid; on pt_ack -> DONE, found=1, last=pid.
- DONE -> IDLE after one cycle; the done flag stays sticky until the next request.
REQ-017 Latency with same-cycle pt_ack: request write in cycle 0; RD cycle 1; PICK cycle 2; CLR cycle 3; status valid cycle 4.
REQ-018 Status read word: [31] busy (state != IDLE), [30] found, [29] done, [28] err, [4:0] pid; all other bits 0.
REQ-019 Timeout: wait counter clears on entering RD or CLR and increments each cycle without pt_ack.
- Counter reaching TIMEOUT -> drop pt_stb, err=1, found=0, go to DONE; last unchanged.
REQ-020 pt_stb is deasserted in the cycle after pt_ack and is never asserted in IDLE, PICK or DONE.
REQ-021 A new request clears found, done and err.

Reset
REQ-022 rst_n=0 at a clock edge:
- state=IDLE, mask=32'hFFFF_FFFF, last=31, pid=0;
- found, done, err, wait counter = 0; pt_stb=0, pt_we=0, pt_data_out=0.
REQ-023 Reset mid-transaction aborts with no further pt_stb; a clear already acked stays done in the timer block.

Structure
REQ-024 Package proc_scan_pkg holds the state enum, ctrl bit indices, status bit indices and the constant PT_CLR_READY=8'h08.
REQ-025 Sub-module rr_pick: combinational 32-bit rotating-priority picker; inputs vector and start index; outputs hit and index.

Verification
REQ-026 Ready vector 32'h0000_0014, last=31, request -> first RD/CLR pair clears pid 2, status 0x6000_0002; second request clears pid 4.
REQ-027 Vector 32'h8000_0001, last=31 -> pid 0; next request -> pid 31; next -> pid 0 (wrap).
REQ-028 Clear mask[2] then vector 32'h0000_0004 -> no CLR issued, status 0x2000_0000.
REQ-029 pt_ack held low, TIMEOUT=15 -> pt_stb drops after 15 cycles in RD, status 0x3000_0000.
REQ-030 rst_n low during CLR -> pt_stb 0 next cycle, status 0, mask all ones, next pick starts at pid 0.
REQ-031 Second ctrl[0] while busy -> ignored, exactly one RD and one CLR observed.
